// File: rtl/bus_arb.sv
// Memory-bus arbiter and access sequencer for the JAVK CPU (fetch, data, DMA).
// Optional round-robin arbitration is enabled by defining BUS_ARB_RR_EN.
module bus_arb #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   addrbus,
  output logic                rw,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("bus_arb: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [2:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addrbus_q, addrbus_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [2:0]          win;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic                we_sel;

`ifdef BUS_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Search starts at ptr and wraps 2 -> 0; first requester found wins.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] res;
    int idx;
    res = '0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(p) + k) % 3;
      if (r[idx] && (res == 3'b000)) res[idx] = 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    win = rr_pick(req, ptr_q);
  end
`else
  always_comb begin
    win = 3'b000;
    if (req[2])      win = 3'b100;
    else if (req[1]) win = 3'b010;
    else if (req[0]) win = 3'b001;
  end
`endif

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (win[i]) begin
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
        we_sel    = we[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = 3'b000;
    rdata_d     = rdata_q;
    addrbus_d   = addrbus_q;
    rw_d        = rw_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
`ifdef BUS_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_d       = win;
          addrbus_d   = addr_sel;
          mem_wdata_d = wdata_sel;
          rw_d        = we_sel;
          state_d     = ACCESS;
`ifdef BUS_ARB_RR_EN
          ptr_d = win[0] ? 2'd1 : (win[1] ? 2'd2 : 2'd0);
`endif
        end
      end
      ACCESS: begin
        if (WAIT_CYCLES == 0) begin
          state_d = DONE;
          ack_d   = gnt_q;
          if (!rw_q) rdata_d = mem_rdata;
        end else begin
          cnt_d   = WAIT_LD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          ack_d   = gnt_q;
          if (!rw_q) rdata_d = mem_rdata;
        end
      end
      DONE: begin
        // addrbus and mem_wdata deliberately hold their last values.
        gnt_d   = 3'b000;
        rw_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      addrbus_q   <= '0;
      rw_q        <= 1'b0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
`ifdef BUS_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      addrbus_q   <= addrbus_d;
      rw_q        <= rw_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
`ifdef BUS_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign addrbus   = addrbus_q;
  assign rw        = rw_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bus_arb.sv
// Directed self-checking bench for bus_arb; one instance with no wait states and
// one with three, both fed from the same requester inputs.
module tb_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [47:0] addr;
  logic [23:0] wdata;
  logic [7:0]  mem_rdata;

  logic [2:0]  gnt0, ack0, gnt3, ack3;
  logic [7:0]  rdata0, mwd0, rdata3, mwd3;
  logic [15:0] addrbus0, addrbus3;
  logic        rw0, rw3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bus_arb #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt0), .ack(ack0), .rdata(rdata0), .addrbus(addrbus0), .rw(rw0),
    .mem_wdata(mwd0), .mem_rdata(mem_rdata)
  );

  bus_arb #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .ack(ack3), .rdata(rdata3), .addrbus(addrbus3), .rw(rw3),
    .mem_wdata(mwd3), .mem_rdata(mem_rdata)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({gnt0, ack0, rdata0, addrbus0, rw0, mwd0} !== 39'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dut0: got gnt=%b ack=%b rdata=%h addr=%h rw=%b wd=%h expected all zero",
               gnt0, ack0, rdata0, addrbus0, rw0, mwd0);
    end
    tests_run++;
    if ({gnt3, ack3, rdata3, addrbus3, rw3, mwd3} !== 39'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dut3: got gnt=%b ack=%b rdata=%h addr=%h rw=%b wd=%h expected all zero",
               gnt3, ack3, rdata3, addrbus3, rw3, mwd3);
    end
  endtask

  task automatic test_fetch_read();
    do_reset();
    req = 3'b001; addr[15:0] = 16'h1234; mem_rdata = 8'hA5;
    tick();
    tests_run++;
    if (addrbus0 !== 16'h1234 || rw0 !== 1'b0 || gnt0 !== 3'b001 || ack0 !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL fetch_access: got addr=%h rw=%b gnt=%b ack=%b expected 1234 0 001 000",
               addrbus0, rw0, gnt0, ack0);
    end
    tick();
    tests_run++;
    if (ack0 !== 3'b001 || rdata0 !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL fetch_ack: got ack=%b rdata=%h expected 001 a5", ack0, rdata0);
    end
    req = 3'b000;
    tick();
    tests_run++;
    if (gnt0 !== 3'b000 || ack0 !== 3'b000 || rw0 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_release: got gnt=%b ack=%b rw=%b expected 000 000 0", gnt0, ack0, rw0);
    end
  endtask

  task automatic test_write_wait();
    do_reset();
    req = 3'b010; we = 3'b010; addr[31:16] = 16'hFF00; wdata[15:8] = 8'h5C; mem_rdata = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (rw3 !== 1'b1 || mwd3 !== 8'h5C || addrbus3 !== 16'hFF00 || ack3 !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL write_hold_T+%0d: got rw=%b wd=%h addr=%h ack=%b expected 1 5c ff00 000",
                 k, rw3, mwd3, addrbus3, ack3);
      end
    end
    tick();
    tests_run++;
    if (ack3 !== 3'b010 || rdata3 !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL write_ack: got ack=%b rdata=%h expected 010 00", ack3, rdata3);
    end
    req = 3'b000; we = 3'b000;
    tick();
    tests_run++;
    if (rw3 !== 1'b0 || gnt3 !== 3'b000 || ack3 !== 3'b000 || addrbus3 !== 16'hFF00) begin
      tests_failed++;
      $display("[TB] FAIL write_release: got rw=%b gnt=%b ack=%b addr=%h expected 0 000 000 ff00",
               rw3, gnt3, ack3, addrbus3);
    end
  endtask

  task automatic test_contention();
    logic [2:0]  exp_order [3];
    logic [15:0] exp_addr;
    do_reset();
`ifdef BUS_ARB_RR_EN
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
`else
    exp_order[0] = 3'b100; exp_order[1] = 3'b010; exp_order[2] = 3'b001;
`endif
    addr = {16'h0300, 16'h0200, 16'h0100};
    for (int round = 0; round < 2; round++) begin
      req = 3'b111;
      for (int n = 0; n < 3; n++) begin
        for (int c = 0; c < 12; c++) begin
          if (ack0 != 3'b000) break;
          tick();
        end
        exp_addr = exp_order[n][2] ? 16'h0300 : (exp_order[n][1] ? 16'h0200 : 16'h0100);
        tests_run++;
        if (ack0 !== exp_order[n] || gnt0 !== exp_order[n] || addrbus0 !== exp_addr) begin
          tests_failed++;
          $display("[TB] FAIL contention_r%0d_n%0d: got ack=%b gnt=%b addr=%h expected %b %b %h",
                   round, n, ack0, gnt0, addrbus0, exp_order[n], exp_order[n], exp_addr);
        end
        req = req & ~ack0;
        tick();
      end
    end
    req = 3'b000;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp_addr;
    do_reset();
    req = 3'b001; addr[15:0] = 16'h0000; mem_rdata = 8'h3E;
    for (int n = 0; n < 3; n++) begin
      lat = 0;
      do begin
        tick();
        lat++;
      end while (ack0 == 3'b000 && lat < 12);
      exp_addr = 16'(n);
      // First access: ACCESS, DONE; later ones add the IDLE re-arbitration cycle.
      tests_run++;
      if (ack0 !== 3'b001 || addrbus0 !== exp_addr || lat != ((n == 0) ? 2 : 3)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_%0d: got ack=%b addr=%h latency=%0d expected 001 %h %0d",
                 n, ack0, addrbus0, lat, exp_addr, (n == 0) ? 2 : 3);
      end
      addr[15:0] = addr[15:0] + 16'd1;
    end
    req = 3'b000;
  endtask

  task automatic test_drop_mid();
    do_reset();
    req = 3'b001; addr[15:0] = 16'h0ABC; mem_rdata = 8'h3C;
    tick();
    tick();
    req = 3'b000;
    tick();
    tick();
    tick();
    tests_run++;
    if (ack3 !== 3'b001 || rdata3 !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL drop_mid_ack: got ack=%b rdata=%h expected 001 3c", ack3, rdata3);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_ack;
    do_reset();
    req = 3'b010; we = 3'b010; addr[31:16] = 16'h4444; wdata[15:8] = 8'h11;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (gnt3 !== 3'b000 || ack3 !== 3'b000 || rw3 !== 1'b0 || addrbus3 !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got gnt=%b ack=%b rw=%b addr=%h expected 000 000 0 0000",
               gnt3, ack3, rw3, addrbus3);
    end
    rst = 1'b0; req = 3'b000; we = 3'b000;
    seen_ack = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack3 != 3'b000) seen_ack = 1'b1;
    end
    tests_run++;
    if (seen_ack !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_no_ack: got ack_seen=%b expected 0", seen_ack);
    end
  endtask

  task automatic test_input_change();
    do_reset();
    req = 3'b010; we = 3'b000; addr[31:16] = 16'h0010; mem_rdata = 8'h42;
    tick();
    addr[31:16] = 16'h0020; we = 3'b010; wdata[15:8] = 8'hEE;
    for (int k = 1; k <= 4; k++) begin
      tests_run++;
      if (addrbus3 !== 16'h0010 || rw3 !== 1'b0 || ack3 !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL input_change_T+%0d: got addr=%h rw=%b ack=%b expected 0010 0 000",
                 k, addrbus3, rw3, ack3);
      end
      tick();
    end
    tests_run++;
    if (ack3 !== 3'b010 || addrbus3 !== 16'h0010 || rdata3 !== 8'h42) begin
      tests_failed++;
      $display("[TB] FAIL input_change_ack: got ack=%b addr=%h rdata=%h expected 010 0010 42",
               ack3, addrbus3, rdata3);
    end
    req = 3'b000; we = 3'b000;
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write_wait();
    test_contention();
    test_back_to_back();
    test_drop_mid();
    test_reset_mid();
    test_input_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
